// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of pending register-file writebacks drained into a registered write port.
// Stored and in-flight destinations are exposed as read-after-write hazards.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rd,
    input  logic [31:0]   in_data,
    input  logic          drain_stall,
    output logic          wr_en,
    output logic [4:0]    wr_rd,
    output logic [31:0]   wr_data,
    input  logic [4:0]    chk_rs1,
    input  logic [4:0]    chk_rs2,
    output logic          hazard1,
    output logic          hazard2,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             wr_en_q;
    logic [4:0]       wr_rd_q;
    logic [31:0]      wr_data_q;
    logic             enq, pop;
    logic [DEPTH-1:0] hit1, hit2;

    assign full     = count_q == (AW+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign in_ready = !full;
    // rd=0 is a discarded writeback: handshake accepted, nothing stored
    assign enq      = in_valid && in_ready && in_rd != '0;
    assign pop      = !empty && !drain_stall;
    assign count_d  = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};

    assign count   = count_q;
    assign wr_en   = wr_en_q;
    assign wr_rd   = wr_rd_q;
    assign wr_data = wr_data_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic occ;
        // slot is live when its distance from the read pointer is below count
        assign occ     = {1'b0, AW'(g) - rptr_q} < count_q;
        assign hit1[g] = occ && rd_q[g] == chk_rs1;
        assign hit2[g] = occ && rd_q[g] == chk_rs2;
    end

    assign hazard1 = chk_rs1 != '0 && (|hit1 || (wr_en_q && wr_rd_q == chk_rs1));
    assign hazard2 = chk_rs2 != '0 && (|hit2 || (wr_en_q && wr_rd_q == chk_rs2));

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[wptr_q]   <= in_rd;
            data_q[wptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
        end else begin
            count_q <= count_d;
            wr_en_q <= pop;
            if (enq) wptr_q <= wptr_q + AW'(1);
            if (pop) begin
                rptr_q    <= rptr_q + AW'(1);
                wr_rd_q   <= rd_q[rptr_q];
                wr_data_q <= data_q[rptr_q];
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed table, multi-cycle corner sequences and random traffic vs a queue model.
module tb_regfile_wb_queue;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, drain_stall, wr_en, hazard1, hazard2, empty, full;
    logic [4:0]  in_rd, wr_rd, chk_rs1, chk_rs2;
    logic [31:0] in_data, wr_data;
    logic [2:0]  count;
    int          n_chk = 0;
    int          n_fail = 0;

    regfile_wb_queue #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_data(in_data), .drain_stall(drain_stall), .wr_en(wr_en), .wr_rd(wr_rd),
        .wr_data(wr_data), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard1(hazard1),
        .hazard2(hazard2), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [4:0] rd; logic [31:0] d; logic st; logic [4:0] s1, s2;
        logic [2:0] cnt; logic rdy, h1, h2, we; logic [4:0] wrd; logic [31:0] wd;
    } vec_t;
    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    logic m_we;
    logic [4:0] m_wrd;
    logic [31:0] m_wd;

    function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [31:0] d,
                                input logic st, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [2:0] cnt, input logic rdy, input logic h1,
                                input logic h2, input logic we, input logic [4:0] wrd,
                                input logic [31:0] wd);
        vec_t r;
        r.v = v; r.rd = rd; r.d = d; r.st = st; r.s1 = s1; r.s2 = s2;
        r.cnt = cnt; r.rdy = rdy; r.h1 = h1; r.h2 = h2; r.we = we; r.wrd = wrd; r.wd = wd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic st, input logic [4:0] s1, input logic [4:0] s2);
        rst = r; in_valid = v; in_rd = rd; in_data = d; drain_stall = st;
        chk_rs1 = s1; chk_rs2 = s2;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic [2:0] c, input logic rdy,
                            input logic h1, input logic h2);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " empty"}, 32'(empty), 32'(c == 3'd0));
        chk({tag, " full"}, 32'(full), 32'(c == 3'd4));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, " hazard1"}, 32'(hazard1), 32'(h1));
        chk({tag, " hazard2"}, 32'(hazard2), 32'(h2));
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, " wr_en"}, 32'(wr_en), 32'(we));
        chk({tag, " wr_rd"}, 32'(wr_rd), 32'(rd));
        chk({tag, " wr_data"}, wr_data, d);
    endtask

    function automatic logic m_haz(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
        return m_we && m_wrd == rs;
    endfunction

    initial begin
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 5, 0, 1, 1, 1, 0, 1, 5, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h0, 0, 5, 0, 0, 1, 1, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h0, 0, 5, 0, 0, 1, 0, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(1, 1, 32'h11, 1, 1, 4, 0, 1, 0, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(1, 2, 32'h22, 1, 1, 4, 1, 1, 1, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(1, 3, 32'h33, 1, 1, 4, 2, 1, 1, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(1, 4, 32'h44, 1, 1, 4, 3, 1, 1, 0, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(1, 9, 32'h99, 1, 1, 4, 4, 0, 1, 1, 0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 32'h0, 0, 9, 4, 4, 0, 0, 1, 1, 1, 32'h11));
        tbl.push_back(mk(0, 0, 32'h0, 0, 9, 1, 3, 1, 0, 1, 1, 2, 32'h22));
        tbl.push_back(mk(0, 0, 32'h0, 0, 9, 1, 2, 1, 0, 0, 1, 3, 32'h33));
        tbl.push_back(mk(0, 0, 32'h0, 0, 9, 1, 1, 1, 0, 0, 1, 4, 32'h44));
        tbl.push_back(mk(0, 0, 32'h0, 0, 9, 1, 0, 1, 0, 0, 0, 4, 32'h44));
        tbl.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 0, 0, 4, 32'h44));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 32'h44));
        tbl.push_back(mk(1, 7, 32'h77, 1, 7, 0, 0, 1, 0, 0, 0, 4, 32'h44));
        tbl.push_back(mk(0, 0, 32'h0, 1, 7, 0, 1, 1, 1, 0, 0, 4, 32'h44));
        tbl.push_back(mk(0, 0, 32'h0, 0, 7, 0, 1, 1, 1, 0, 1, 7, 32'h77));
        tbl.push_back(mk(0, 0, 32'h0, 0, 7, 0, 0, 1, 1, 0, 0, 7, 32'h77));
        tbl.push_back(mk(0, 0, 32'h0, 0, 7, 0, 0, 1, 0, 0, 0, 7, 32'h77));

        drive(1, 1, 5'd3, 32'h1234, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_comb("reset", 0, 1, 0, 0);
        chk_wr("reset", 0, 0, 0);

        foreach (tbl[i]) begin
            drive(0, tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].st, tbl[i].s1, tbl[i].s2);
            chk_comb($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].rdy, tbl[i].h1, tbl[i].h2);
            tick();
            chk_wr($sformatf("vec%0d", i), tbl[i].we, tbl[i].wrd, tbl[i].wd);
        end

        // same-edge push and pop at count 2
        drive(0, 1, 10, 32'hA0, 1, 0, 0); tick();
        drive(0, 1, 11, 32'hB0, 1, 0, 0); tick();
        drive(0, 1, 12, 32'hC0, 0, 0, 0);
        chk_comb("pp0", 2, 1, 0, 0);
        tick();
        chk_wr("pp0", 1, 10, 32'hA0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_comb("pp1", 2, 1, 0, 0);
        tick();
        chk_wr("pp1", 1, 11, 32'hB0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_comb("pp2", 1, 1, 0, 0);
        tick();
        chk_wr("pp2", 1, 12, 32'hC0);

        // reset with three entries queued discards them
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 5'(13 + k), 32'(k), 1, 0, 0);
            tick();
        end
        drive(1, 1, 16, 32'hF0, 0, 13, 0);
        chk_comb("rst3", 3, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 13, 15);
        chk_comb("rst3 post", 0, 1, 0, 0);
        chk_wr("rst3 post", 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 13, 16);
            chk_comb($sformatf("stale%0d", k), 0, 1, 0, 0);
            tick();
            chk_wr($sformatf("stale%0d", k), 0, 0, 0);
        end

        // random traffic against the queue model
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        mq.delete();
        m_we = 1'b0; m_wrd = '0; m_wd = '0;
        for (int c = 0; c < 10000; c++) begin
            logic r, v, st, rdy;
            logic [4:0] rd, s1, s2;
            logic [31:0] d;
            ent_t e;
            r = $urandom_range(0, 499) == 0;
            v = $urandom_range(0, 1) == 1;
            st = $urandom_range(0, 9) < 4;
            rd = 5'($urandom_range(0, 7));
            d = $urandom;
            s1 = 5'($urandom_range(0, 7));
            s2 = 5'($urandom_range(0, 7));
            drive(r, v, rd, d, st, s1, s2);
            rdy = mq.size() < 4;
            chk_comb($sformatf("rnd%0d", c), 3'(mq.size()), rdy, m_haz(s1), m_haz(s2));
            if (r) begin
                mq.delete();
                m_we = 1'b0; m_wrd = '0; m_wd = '0;
            end else begin
                if (mq.size() > 0 && !st) begin
                    e = mq.pop_front();
                    m_we = 1'b1; m_wrd = e.rd; m_wd = e.d;
                end else m_we = 1'b0;
                if (v && rdy && rd != 5'd0) begin
                    e.rd = rd; e.d = d;
                    mq.push_back(e);
                end
            end
            tick();
            chk_wr($sformatf("rnd%0d", c), m_we, m_wrd, m_wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 The block SHALL have one clock and one reset: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-high reset.
REQ-002 The block SHALL have these parameters:
- DEPTH, 4, queue entries (power of two).
- AW, 2, log2(DEPTH).
REQ-003 The block SHALL have these ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  producer offers a writeback
- in_ready  out  1  queue can accept
- in_rd  in  5  destination register index
- in_data  in  32  result value
- drain_stall  in  1  register file busy; no write issued this cycle
- wr_en  out  1  register file write strobe (registered)
- wr_rd  out  5  register file write index (registered)
- wr_data  out  32  register file write data (registered)
- chk_rs1  in  5  source index 1 to check for pending write
- chk_rs2  in  5  source index 2 to check for pending write
- hazard1  out  1  chk_rs1 has a pending write
- hazard2  out  1  chk_rs2 has a pending write
- count  out  AW+1  occupied entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Function
REQ-004 Push SHALL occur on a clk edge where in_valid=1 and in_ready=1; in_ready SHALL equal !full (combinational, no same-cycle bypass).
REQ-005 A push with in_rd=0 SHALL complete the handshake but SHALL NOT enqueue; count SHALL not change from it.
REQ-006 Entries SHALL be stored at the write pointer; the write pointer SHALL increment mod DEPTH on each enqueue.
REQ-007 Pop SHALL occur on a clk edge where count>0 and drain_stall=0; the head entry SHALL be loaded into wr_rd/wr_data with wr_en=1 on that edge, and the read pointer SHALL increment mod DEPTH.
REQ-008 On any edge without a pop, wr_en SHALL be 0; wr_rd and wr_data SHALL hold their previous values.
REQ-009 Pops SHALL preserve strict FIFO order; at most one pop and one push per cycle.
REQ-010 Simultaneous enqueue and pop SHALL leave count unchanged; when full, in_ready=0 even if a pop occurs that cycle.
REQ-011 The pop at count=1 and the enqueue at count=0 SHALL be handled without underflow: an entry becomes poppable no earlier than the edge after its push.
REQ-012 hazard1 SHALL be 1 iff chk_rs1!=0 and chk_rs1 matches either the rd of any occupied queue entry or wr_rd while wr_en=1; hazard2 SHALL be 1 under the same rule for chk_rs2; both SHALL be combinational.
REQ-013 empty and full SHALL be decoded combinationally from count.

Reset
REQ-014 On a clk edge with rst=1, count, both pointers, wr_en, wr_rd and wr_data SHALL become 0, regardless of in_valid or drain_stall.
REQ-015 Entries queued before reset SHALL be discarded and SHALL NOT produce a write after reset.
REQ-016 Storage contents SHALL not need reset; hazards SHALL depend only on occupied entries.

Verification
REQ-017 Reset, then push (rd=5, 0xDEADBEEF) with drain_stall=0 -> next edge wr_en=1, wr_rd=5, wr_data=0xDEADBEEF; following edge wr_en=0, wr_rd/wr_data held.
REQ-018 drain_stall=1, push rd=1..4 data 0x11..0x44 -> count=4, full=1, in_ready=0; a fifth push is refused; release stall -> wr writes rd 1,2,3,4 on four consecutive edges, then empty=1.
REQ-019 Push rd=0 data 0xFFFFFFFF -> handshake completes, count stays 0, no wr_en pulse.
REQ-020 Queue holds rd=7, chk_rs1=7, chk_rs2=0 -> hazard1=1, hazard2=0; after pop, hazard1 stays 1 while wr_en=1 with wr_rd=7, then 0.
REQ-021 count=2 with push and pop on the same edge -> count stays 2, order preserved; assert rst with count=3 -> count=0, wr_en=0, no stale writes afterwards.
REQ-022 Randomized push/stall traffic against a FIFO model for 10000 cycles -> write sequence, count and hazards match the model every cycle.
